// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg: shared types, default widths and helpers for the skid    |
// | buffered pipeline stage.   Revision: 1.0                           |
// +--------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 160;
  localparam int DEF_TNEW_W = 3;

  // Decrement that stops at zero; callers narrow the result to their width.
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter16: 16-bit up counter that sticks at 0xFFFF.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage_skid: two-entry (main + skid) pipeline register with    |
// | Tnew decrement, flush and starvation counter.   Revision: 1.0      |
// +--------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TNEW_W   = DEF_TNEW_W,
  parameter int DEC_TNEW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [15:0]       bubble_cnt
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [TNEW_W-1:0]   main_tnew_q, main_tnew_d;
  logic [TNEW_W-1:0]   skid_tnew_q, skid_tnew_d;
  logic [TNEW_W-1:0]   w_cap_tnew;
  logic                w_in_fire;
  logic                w_out_fire;

  generate
    if (DEC_TNEW != 0) begin : g_dec_tnew
      assign w_cap_tnew = TNEW_W'(sat_dec(32'(in_tnew)));
    end else begin : g_pass_tnew
      assign w_cap_tnew = in_tnew;
    end
  endgenerate

  assign in_ready   = (state_q != ST_TWO);
  assign out_valid  = (state_q != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    main_tnew_d = main_tnew_q;
    skid_tnew_d = skid_tnew_q;
    if (clear) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      skid_data_d = '0;
      main_tnew_d = '0;
      skid_tnew_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in_fire) begin
            main_data_d = in_data;
            main_tnew_d = w_cap_tnew;
            state_d     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            main_data_d = in_data;
            main_tnew_d = w_cap_tnew;
          end else if (w_in_fire) begin
            skid_data_d = in_data;
            skid_tnew_d = w_cap_tnew;
            state_d     = ST_TWO;
          end else if (w_out_fire) begin
            state_d     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Skid Tnew was already decremented at capture; move it as-is.
          if (w_out_fire) begin
            main_data_d = skid_data_q;
            main_tnew_d = skid_tnew_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      main_tnew_q <= '0;
      skid_tnew_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      main_tnew_q <= main_tnew_d;
      skid_tnew_q <= skid_tnew_d;
    end
  end

  assign out_data = out_valid ? main_data_q : '0;
  assign out_tnew = out_valid ? main_tnew_q : '0;

  sat_counter16 u_bubble_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (out_ready & ~out_valid),
    .count_o (bubble_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_stage_skid: directed vector bench for pipe_stage_skid.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int DW = 160;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tnew;
  logic          out_ready;

  logic          in_ready,  in_ready0;
  logic          out_valid, out_valid0;
  logic [DW-1:0] out_data,  out_data0;
  logic [TW-1:0] out_tnew,  out_tnew0;
  logic [15:0]   bubble_cnt, bubble_cnt0;

  int n_tests  = 0;
  int n_failed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .TNEW_W(TW), .DEC_TNEW(1)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tnew(in_tnew),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tnew(out_tnew), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .TNEW_W(TW), .DEC_TNEW(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_tnew(in_tnew),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_tnew(out_tnew0), .bubble_cnt(bubble_cnt0)
  );

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          clr;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_d;
    logic [TW-1:0] e_t;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_tnew = '0; out_ready = 1'b0;

    // iv ordy clr data tnew | in_ready out_valid out_data out_tnew (after the edge)
    vecs[0]  = '{1, 1, 0, DW'('h01), 3'd3, 1, 1, DW'('h01), 3'd2};
    vecs[1]  = '{1, 1, 0, DW'('h02), 3'd3, 1, 1, DW'('h02), 3'd2};
    vecs[2]  = '{0, 1, 0, DW'('h00), 3'd0, 1, 0, DW'('h00), 3'd0};
    vecs[3]  = '{1, 0, 0, DW'('hA0), 3'd0, 1, 1, DW'('hA0), 3'd0};
    vecs[4]  = '{1, 0, 0, DW'('hB0), 3'd7, 0, 1, DW'('hA0), 3'd0};
    vecs[5]  = '{1, 0, 0, DW'('hC0), 3'd4, 0, 1, DW'('hA0), 3'd0};
    vecs[6]  = '{0, 1, 0, DW'('h00), 3'd0, 1, 1, DW'('hB0), 3'd6};
    vecs[7]  = '{0, 1, 0, DW'('h00), 3'd0, 1, 0, DW'('h00), 3'd0};
    vecs[8]  = '{1, 1, 0, DW'('hD0), 3'd1, 1, 1, DW'('hD0), 3'd0};
    vecs[9]  = '{1, 0, 0, DW'('hE0), 3'd2, 0, 1, DW'('hD0), 3'd0};
    vecs[10] = '{1, 0, 1, DW'('hF0), 3'd5, 1, 0, DW'('h00), 3'd0};
    vecs[11] = '{0, 1, 0, DW'('h00), 3'd0, 1, 0, DW'('h00), 3'd0};

    #2;
    check("rst_in_ready",  DW'(in_ready),   DW'(1));
    check("rst_out_valid", DW'(out_valid),  DW'(0));
    check("rst_out_data",  out_data,        DW'(0));
    check("rst_out_tnew",  DW'(out_tnew),   DW'(0));
    check("rst_bubble",    DW'(bubble_cnt), DW'(0));
    tick();
    reset = 1'b0;

    // Streaming: first edge is starved (bubble), then 8 payloads back to back.
    in_valid = 1'b1; out_ready = 1'b1; in_tnew = 3'd3;
    for (int k = 0; k < 8; k++) begin
      in_data = DW'(32'h100 + k);
      tick();
      check($sformatf("stream_data%0d", k), out_data, DW'(32'h100 + k));
      check($sformatf("stream_tnew%0d", k), DW'(out_tnew), DW'(2));
    end
    check("stream_bubble", DW'(bubble_cnt), DW'(1));
    in_valid = 1'b0; out_ready = 1'b0;

    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy; clear = vecs[i].clr;
      in_data = vecs[i].d; in_tnew = vecs[i].t;
      tick();
      check($sformatf("v%0d_in_ready", i),  DW'(in_ready),  DW'(vecs[i].e_ir));
      check($sformatf("v%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
      check($sformatf("v%0d_out_data", i),  out_data,       vecs[i].e_d);
      check($sformatf("v%0d_out_tnew", i),  DW'(out_tnew),  DW'(vecs[i].e_t));
    end
    clear = 1'b0; in_valid = 1'b0;
    // Flushed payload F must never appear.
    out_ready = 1'b1;
    tick();
    check("flush_absent", DW'(out_valid), DW'(0));

    // Tnew pass-through vs decrement.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_data = DW'('h55); in_tnew = 3'd5;
    tick();
    in_valid = 1'b0;
    check("nodec_tnew", DW'(out_tnew0), DW'(5));
    check("dec_tnew",   DW'(out_tnew),  DW'(4));
    check("nodec_data", out_data0,      DW'('h55));

    // Async reset between edges while in ONE; bubble_cnt is nonzero beforehand.
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b1; out_ready = 1'b0; in_data = DW'('h77); in_tnew = 3'd2;
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid",  DW'(out_valid),            DW'(1));
    check("ar_pre_bubble", DW'(bubble_cnt != 16'd0),  DW'(1));
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", DW'(out_valid),  DW'(0));
    check("ar_bubble",    DW'(bubble_cnt), DW'(0));
    check("ar_out_data",  out_data,        DW'(0));
    check("ar_in_ready",  DW'(in_ready),   DW'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Saturation then clear with the counter otherwise idle.
    out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("sat_bubble", DW'(bubble_cnt), DW'(16'hFFFF));
    out_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("sat_after_clear", DW'(bubble_cnt), DW'(16'hFFFF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, meaning the width of the payload bundle (instruction, PC+8, operands, control fields).
REQ-002 The block SHALL have parameter TNEW_W, default 3, meaning the width of the hazard Tnew field.
REQ-003 The block SHALL have parameter DEC_TNEW, default 1, meaning Tnew is decremented on capture when 1 and passed unchanged when 0.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-007 The block SHALL have port clear, input, 1 bit, the synchronous flush (bubble insertion).
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the upstream stage offers a payload.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the stage accepts a payload this cycle.
REQ-010 The block SHALL have port in_data, input, DATA_W bits, the upstream payload.
REQ-011 The block SHALL have port in_tnew, input, TNEW_W bits, the upstream Tnew.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning the stage presents a payload.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts (low = stall).
REQ-014 The block SHALL have port out_data, output, DATA_W bits, the presented payload.
REQ-015 The block SHALL have port out_tnew, output, TNEW_W bits, the presented Tnew.
REQ-016 The block SHALL have port bubble_cnt, output, 16 bits, counting cycles downstream was ready but starved.

Function
REQ-017 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 The block SHALL implement states EMPTY, ONE (main entry valid) and TWO (main and skid entries valid); in_ready = (state != TWO); out_valid = (state != EMPTY); both are decoded from registered state only.
REQ-019 In EMPTY, in_fire SHALL load main and go to ONE.
REQ-020 In ONE, in_fire & out_fire SHALL reload main and stay in ONE; in_fire alone SHALL load skid and go to TWO; out_fire alone SHALL go to EMPTY.
REQ-021 In TWO, out_fire SHALL move skid to main and go to ONE; with no out_fire, the state SHALL hold.
REQ-022 Throughput SHALL be one payload per cycle when out_ready is held high, and capture-to-output latency SHALL be one cycle.
REQ-023 When DEC_TNEW=1, Tnew SHALL be stored as in_tnew-1 saturating at 0 on capture into main or skid, with no further change on a skid-to-main move.
REQ-024 out_data and out_tnew SHALL be zero whenever out_valid=0.
REQ-025 clear SHALL force state EMPTY and zero main, skid and Tnew at the next edge; any same-cycle in_fire SHALL be discarded; clear SHALL override all transitions.
REQ-026 bubble_cnt SHALL increment when out_ready=1 and out_valid=0, saturate at 0xFFFF, and be unaffected by clear.
REQ-027 Payload order SHALL be strictly preserved: no drop and no duplication except on clear.

Reset
REQ-028 Reset SHALL asynchronously force state EMPTY, main/skid data 0, Tnew 0 and bubble_cnt 0, giving in_ready=1, out_valid=0 and outputs 0.
REQ-029 Reset asserted mid-operation SHALL discard both entries immediately, without waiting for a clock edge.

Structure
REQ-030 Package pipe_pkg SHALL hold the state encoding typedef, the default DATA_W/TNEW_W constants and the saturating-decrement function.
REQ-031 The block SHALL instantiate one sub-module, sat_counter16, for bubble_cnt; the FSM and datapath SHALL be inline.

Verification
REQ-032 Streaming: out_ready=1 with in_valid=1 for 8 cycles, in_tnew=3 -> 8 payloads out in order with 1-cycle latency, out_tnew=2, bubble_cnt=1.
REQ-033 Stall: out_ready=0 while sending A then B -> state TWO, in_ready=0, out_data=A held; release -> A then B on consecutive cycles.
REQ-034 Flush: clear=1 in state TWO with in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1, the offered payload absent later.
REQ-035 Tnew boundary: in_tnew=0 with DEC_TNEW=1 -> out_tnew=0; DEC_TNEW=0 with in_tnew=5 -> out_tnew=5.
REQ-036 Async reset: assert reset between edges in state ONE -> out_valid=0 and bubble_cnt=0 before the next edge.
REQ-037 Saturation: 70000 starved cycles -> bubble_cnt=0xFFFF, and clear leaves it unchanged.
